dmem_io_responder: RTL and testbench

DMEM_IO_RESPONDER -- requirements
Module: dmem_io_responder

---
 rtl/dmem_io_responder_if.sv | 11 +
 rtl/dmem_io_responder.sv | 141 ++++++++++++++
 tb/tb_dmem_io_responder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_io_responder_if.sv
// Data-memory bus between the CPU MEM stage and the RAM/I-O responder.
// The CPU drives address, store data and strobe; the responder answers with zero-wait load data.
interface dmem_io_responder_if;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        we;
  logic [31:0] dataout;

  modport master (output addr, output datain, output we, input dataout);
  modport slave  (input addr, input datain, input we, output dataout);
endinterface

// File: rtl/dmem_io_responder.sv
// 32-word RAM plus memory-mapped switches, keys with falling-edge flags, LEDs and a down-counting timer.
// Loads are combinational from addr; stores take effect on the rising clock edge.
module dmem_io_responder (
  input  logic                 clock,
  input  logic                 resetn,
  dmem_io_responder_if.slave   bus,
  input  logic [9:0]           sw,
  input  logic [3:0]           key,
  output logic [9:0]           led,
  output logic                 irq
);

  logic [31:0] ram [0:31];

  logic [9:0]  sw_s1_q,    sw_s1_d;
  logic [9:0]  sw_s2_q,    sw_s2_d;
  logic [3:0]  key_s1_q,   key_s1_d;
  logic [3:0]  key_s2_q,   key_s2_d;
  logic [3:0]  key_prev_q, key_prev_d;
  logic [3:0]  key_edge_q, key_edge_d;
  logic [9:0]  led_q,      led_d;
  logic [1:0]  tctrl_q,    tctrl_d;
  logic [31:0] tload_q,    tload_d;
  logic [31:0] tcount_q,   tcount_d;
  logic        tstat_q,    tstat_d;

  logic        io_we;
  logic [4:0]  io_off;
  logic [3:0]  key_fall;
  logic [3:0]  edge_clr;
  logic        expire;
  logic [31:0] rd_data;

  assign io_we  = bus.we & bus.addr[7];
  assign io_off = bus.addr[6:2];

  // RAM has no reset so its contents survive resetn; stores are blocked while reset is held.
  always_ff @(posedge clock) begin
    if (resetn && bus.we && !bus.addr[7]) begin
      ram[bus.addr[6:2]] <= bus.datain;
    end
  end

  always_comb begin
    sw_s1_d    = sw;
    sw_s2_d    = sw_s1_q;
    key_s1_d   = key;
    key_s2_d   = key_s1_q;
    key_prev_d = key_s2_q;
    led_d      = led_q;
    tctrl_d    = tctrl_q;
    tload_d    = tload_q;
    tcount_d   = tcount_q;
    tstat_d    = tstat_q;
    edge_clr   = 4'b0000;

    key_fall = key_prev_q & ~key_s2_q;
    expire   = tctrl_q[0] && (tcount_q == 32'd0);

    if (tctrl_q[0]) begin
      if (tcount_q != 32'd0) begin
        tcount_d = tcount_q - 32'd1;
      end else if (tctrl_q[1]) begin
        tcount_d = tload_q;
      end else begin
        tctrl_d[0] = 1'b0;
      end
    end

    // Software stores are applied after the hardware timer update so TLOAD and TCTRL writes win.
    if (io_we) begin
      case (io_off)
        5'd2: edge_clr = bus.datain[3:0];
        5'd3: led_d    = bus.datain[9:0];
        5'd4: tctrl_d  = bus.datain[1:0];
        5'd5: begin
          tload_d  = bus.datain;
          tcount_d = bus.datain;
        end
        5'd7: if (bus.datain[0]) tstat_d = 1'b0;
        default: ;
      endcase
    end

    // Hardware set events beat same-cycle write-one-to-clear.
    if (expire) tstat_d = 1'b1;
    key_edge_d = (key_edge_q & ~edge_clr) | key_fall;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      key_s1_q   <= '1;
      key_s2_q   <= '1;
      key_prev_q <= '1;
      key_edge_q <= '0;
      led_q      <= '0;
      tctrl_q    <= '0;
      tload_q    <= '0;
      tcount_q   <= '0;
      tstat_q    <= 1'b0;
    end else begin
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      key_s1_q   <= key_s1_d;
      key_s2_q   <= key_s2_d;
      key_prev_q <= key_prev_d;
      key_edge_q <= key_edge_d;
      led_q      <= led_d;
      tctrl_q    <= tctrl_d;
      tload_q    <= tload_d;
      tcount_q   <= tcount_d;
      tstat_q    <= tstat_d;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    if (!bus.addr[7]) begin
      rd_data = ram[bus.addr[6:2]];
    end else begin
      case (io_off)
        5'd0: rd_data = {22'd0, sw_s2_q};
        5'd1: rd_data = {28'd0, key_s2_q};
        5'd2: rd_data = {28'd0, key_edge_q};
        5'd3: rd_data = {22'd0, led_q};
        5'd4: rd_data = {30'd0, tctrl_q};
        5'd5: rd_data = tload_q;
        5'd6: rd_data = tcount_q;
        5'd7: rd_data = {31'd0, tstat_q};
        default: rd_data = 32'd0;
      endcase
    end
  end

  assign bus.dataout = rd_data;
  assign led         = led_q;
  assign irq         = tstat_q | (|key_edge_q);

endmodule

// File: tb/tb_dmem_io_responder.sv
// Directed scenarios plus randomized bus/switch/key traffic, compared against a
// cycle-level behavioural model of the memory map, synchronizer delay lines and timer rules.
module tb_dmem_io_responder;

  logic       clock = 1'b0;
  logic       resetn;
  logic [9:0] sw;
  logic [3:0] key;
  wire  [9:0] led;
  wire        irq;

  dmem_io_responder_if bus ();

  dmem_io_responder dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave),
    .sw     (sw),
    .key    (key),
    .led    (led),
    .irq    (irq)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_ram    [0:31];
  bit          m_ram_ok [0:31];
  logic [9:0]  s_hist   [0:1];   // [0] sampled last edge, [1] = value visible to reads
  logic [3:0]  k_hist   [0:2];   // [2] is the previous synchronized value
  logic [3:0]  m_kedge;
  logic [9:0]  m_led;
  bit          m_en, m_auto, m_tstat;
  logic [31:0] m_tload, m_tcount;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    s_hist[0] = '0; s_hist[1] = '0;
    for (int i = 0; i < 3; i++) k_hist[i] = 4'hF;
    m_kedge = '0; m_led = '0;
    m_en = 0; m_auto = 0; m_tstat = 0;
    m_tload = '0; m_tcount = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!a[7]) return m_ram[a[6:2]];
    case (a[6:2])
      5'd0: return {22'd0, s_hist[1]};
      5'd1: return {28'd0, k_hist[1]};
      5'd2: return {28'd0, m_kedge};
      5'd3: return {22'd0, m_led};
      5'd4: return {30'd0, m_auto, m_en};
      5'd5: return m_tload;
      5'd6: return m_tcount;
      5'd7: return {31'd0, m_tstat};
      default: return 32'd0;
    endcase
  endfunction

  // One rising edge of the specified behaviour, using the inputs held at that edge.
  task automatic model_edge();
    logic [31:0] a, d;
    bit          w, expiry;
    logic [3:0]  fall, clr;
    if (!resetn) begin
      model_reset();
      return;
    end
    a = bus.addr; d = bus.datain; w = bus.we;
    clr    = 4'b0;
    expiry = m_en && (m_tcount == 0);
    fall   = k_hist[2] & ~k_hist[1];
    k_hist[2] = k_hist[1]; k_hist[1] = k_hist[0]; k_hist[0] = key;
    s_hist[1] = s_hist[0]; s_hist[0] = sw;
    if (m_en) begin
      if (m_tcount != 0) m_tcount = m_tcount - 1;
      else if (m_auto)   m_tcount = m_tload;
      else               m_en = 0;
    end
    if (w && !a[7]) begin
      m_ram[a[6:2]] = d;
      m_ram_ok[a[6:2]] = 1;
    end else if (w) begin
      case (a[6:2])
        5'd2: clr = d[3:0];
        5'd3: m_led = d[9:0];
        5'd4: begin m_en = d[0]; m_auto = d[1]; end
        5'd5: begin m_tload = d; m_tcount = d; end
        5'd7: if (d[0]) m_tstat = 0;
        default: ;
      endcase
    end
    if (expiry) m_tstat = 1;
    m_kedge = (m_kedge & ~clr) | fall;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check_eq("led", {22'd0, led}, {22'd0, m_led});
    check_eq("irq", {31'd0, irq}, {31'd0, (m_tstat | (|m_kedge))});
    if (bus.addr[7] || m_ram_ok[bus.addr[6:2]])
      check_eq("rd_model", bus.dataout, m_read(bus.addr));
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a; bus.datain = d; bus.we = 1'b1;
    $display("store addr=0x%08h data=0x%08h", a, d);
    tick();
    bus.we = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a; bus.we = 1'b0;
    #1;
    $display("load  addr=0x%08h data=0x%08h", a, bus.dataout);
    check_eq(tag, bus.dataout, exp);
  endtask

  initial begin
    int  guard;
    logic [31:0] ra;
    for (int i = 0; i < 32; i++) begin m_ram[i] = '0; m_ram_ok[i] = 0; end
    resetn = 1'b0; sw = '0; key = 4'hF;
    bus.addr = '0; bus.datain = '0; bus.we = 1'b0;
    model_reset();
    tick(); tick();
    @(negedge clock); resetn = 1'b1;

    // Reset state
    load_check("rst_tcount", 32'h98, 32'd0);
    load_check("rst_tctrl",  32'h90, 32'd0);
    load_check("rst_key",    32'h84, 32'hF);
    check_eq("rst_led", {22'd0, led}, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);

    // RAM with aliasing
    store(32'h14, 32'hDEADBEEF);
    load_check("ram_14",    32'h14,  32'hDEADBEEF);
    load_check("ram_114",   32'h114, 32'hDEADBEEF);
    load_check("io_94",     32'h94,  32'd0);

    // LED and unmapped/RO stores
    store(32'h8C, 32'hFFFFFFFF);
    check_eq("led_all", {22'd0, led}, 32'h3FF);
    load_check("led_rd", 32'h8C, 32'h3FF);
    store(32'h98, 32'h55);
    load_check("tcount_ro", 32'h98, 32'd0);
    store(32'hA0, 32'h1234);
    load_check("unmapped", 32'hA0, 32'd0);
    load_check("ram_kept", 32'h14, 32'hDEADBEEF);
    store(32'h8C, 32'h0);

    // One-shot timer
    store(32'h94, 32'd3);
    store(32'h90, 32'd1);
    load_check("os_c3", 32'h98, 32'd3);
    tick(); load_check("os_c2", 32'h98, 32'd2);
    tick(); load_check("os_c1", 32'h98, 32'd1);
    tick(); load_check("os_c0", 32'h98, 32'd0);
    load_check("os_st0", 32'h9C, 32'd0);
    tick();
    load_check("os_st1", 32'h9C, 32'd1);
    load_check("os_en0", 32'h90, 32'd0);
    check_eq("os_irq1", {31'd0, irq}, 32'd1);
    store(32'h9C, 32'd1);
    check_eq("os_irq0", {31'd0, irq}, 32'd0);

    // Auto-reload with W1C on the expiry cycle
    store(32'h94, 32'd2);
    store(32'h90, 32'd3);
    load_check("ar_c2", 32'h98, 32'd2);
    tick(); load_check("ar_c1", 32'h98, 32'd1);
    tick(); load_check("ar_c0", 32'h98, 32'd0);
    store(32'h9C, 32'd1);
    load_check("ar_st", 32'h9C, 32'd1);
    load_check("ar_rl", 32'h98, 32'd2);
    store(32'h90, 32'd0);
    store(32'h9C, 32'd1);

    // Key falling edge
    key = 4'hB;
    tick(); tick();
    load_check("ke_early", 32'h88, 32'd0);
    tick();
    load_check("ke_set", 32'h88, 32'h4);
    load_check("ke_key", 32'h84, 32'hB);
    check_eq("ke_irq", {31'd0, irq}, 32'd1);
    store(32'h88, 32'h4);
    load_check("ke_clr", 32'h88, 32'd0);
    key = 4'hF; tick(); tick(); tick();
    key = 4'hB; tick(); tick(); tick();
    load_check("ke_again", 32'h88, 32'h4);
    store(32'h88, 32'hF);
    key = 4'hF;

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) sw = 10'($urandom);
      if ($urandom_range(0, 7) == 0) key = 4'($urandom);
      if ($urandom_range(0, 1) == 0)
        ra = {$urandom, 1'b0, 5'($urandom), 2'($urandom)} & 32'hFFFFFF7F | 32'($urandom_range(0, 1)) << 7;
      else
        ra = {24'($urandom), 1'b1, 3'd0, 2'($urandom), 2'($urandom)} | {27'd0, 5'($urandom_range(0, 7)) & 5'h7, 2'b00} & 32'hFFFFFFFF;
      ra[6:2] = ra[7] ? 5'($urandom_range(0, 9)) : 5'($urandom);
      bus.addr   = ra;
      bus.we     = ($urandom_range(0, 1) == 1);
      bus.datain = (ra[7] && ra[6:2] == 5'd5) ? 32'($urandom_range(0, 6)) : $urandom;
      #1;
      if (bus.addr[7] || m_ram_ok[bus.addr[6:2]])
        check_eq("rnd_rd", bus.dataout, m_read(bus.addr));
      tick();
    end
    bus.we = 1'b0;
    key = 4'hF;

    // Reset mid-countdown
    store(32'h3C, 32'hCAFEF00D);
    store(32'h8C, 32'h2A5);
    store(32'h94, 32'd100);
    store(32'h90, 32'd1);
    guard = 0;
    while (m_tcount != 32'd50 && guard < 200) begin
      tick();
      guard++;
    end
    check_eq("mid_reach50", 32'(guard < 200), 32'd1);
    load_check("mid_c50", 32'h98, 32'd50);
    @(negedge clock); #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_eq("mr_led", {22'd0, led}, 32'd0);
    check_eq("mr_irq", {31'd0, irq}, 32'd0);
    load_check("mr_tcount", 32'h98, 32'd0);
    load_check("mr_tstat",  32'h9C, 32'd0);
    bus.addr = 32'h3C; bus.datain = 32'h12345678; bus.we = 1'b1;
    tick(); tick();
    bus.we = 1'b0;
    @(negedge clock); resetn = 1'b1;
    load_check("mr_ram", 32'h3C, 32'hCAFEF00D);
    tick(); tick();
    load_check("mr_noexp", 32'h9C, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
